// File: rtl/win_acc_if.sv
// Sample-in / window-sum-out handshake bundle for win_acc.
interface win_acc_if #(parameter int N = 4);
  logic         in_vld;
  logic [N-1:0] d;
  logic [2:0]   len;
  logic         in_rdy;
  logic [N+2:0] sum;
  logic         out_vld;
  logic         out_rdy;
  logic [2:0]   cnt;

  modport master (output in_vld, d, len, out_rdy,
                  input  in_rdy, sum, out_vld, cnt);
  modport slave  (input  in_vld, d, len, out_rdy,
                  output in_rdy, sum, out_vld, cnt);
endinterface

// File: rtl/win_acc.sv
// Windowed accumulator: sums len samples (0 = 8) and holds the sum until taken.
// Optional macro WIN_ACC_OVF_EN adds a sticky ovr flag for samples dropped in HOLD.
module win_acc #(parameter int N = 4) (
  input  logic clk,
  input  logic clr,
`ifdef WIN_ACC_OVF_EN
  output logic ovr,
`endif
  win_acc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t       state_q, state_d;
  logic [N+2:0] acc_q, acc_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [2:0]   win_q, win_d;   // latched length code, 0 encodes 8
  logic [2:0]   cnt_inc;

  assign cnt_inc = cnt_q + 3'd1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  // 3-bit count wraps to 0 on the 8th sample, matching the 0 = 8 length code
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    case (state_q)
      IDLE: if (bus.in_vld) begin
        acc_d   = {3'b000, bus.d};
        cnt_d   = 3'd1;
        win_d   = bus.len;
        state_d = (bus.len == 3'd1) ? HOLD : ACC;
      end
      ACC: if (bus.in_vld) begin
        acc_d = acc_q + {3'b000, bus.d};
        cnt_d = cnt_inc;
        if (cnt_inc == win_q) state_d = HOLD;
      end
      HOLD: if (bus.out_rdy) begin
        cnt_d   = 3'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_rdy  = (state_q != HOLD);
  assign bus.out_vld = (state_q == HOLD);
  assign bus.sum     = (state_q == HOLD) ? acc_q : '0;
  assign bus.cnt     = cnt_q;

`ifdef WIN_ACC_OVF_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                              ovr <= 1'b0;
    else if (state_q == HOLD && bus.in_vld) ovr <= 1'b1;
  end
`endif
endmodule
